noc_tx_arb: RTL and testbench

NOC_TX_ARB -- requirements
Module: noc_tx_arb

---
 rtl/noc_pkg.sv | 21 ++
 rtl/rr_arb.sv | 29 ++
 rtl/noc_tx_arb.sv | 123 ++++++++++++
 tb/tb_noc_tx_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the dual-rail NoC transmit arbiter: default word width,
// FSM state encoding and dual-rail pair helpers.
package noc_pkg;

    localparam int NOC_WID = 16;

    localparam int          PAIR_W     = 2;
    localparam logic [1:0]  PAIR_EMPTY = 2'b00;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEND    = 2'b01,
        RELEASE = 2'b10
    } state_e;

    // A pair carries data once either rail is high (11 is accepted as data too).
    function automatic logic pair_valid(input logic [PAIR_W-1:0] p);
        return p != PAIR_EMPTY;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin winner search: first valid index at or after rr_ptr,
// taken in cyclic order.
module rr_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any_valid
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest valid index is written last.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (valid[idx]) begin
                winner = ID_W'(idx);
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/noc_tx_arb.sv
// Arbitrates N_REQ dual-rail four-phase requesters onto one downstream TX port,
// holding the granted word until downstream acknowledges, then releasing the requester.
module noc_tx_arb #(
    parameter int NOC_WID = noc_pkg::NOC_WID,
    parameter int N_REQ   = 4,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*2*NOC_WID-1:0] req_d,
    output logic [N_REQ-1:0]          req_ack,
    output logic [2*NOC_WID-1:0]      out_d,
    input  logic                      out_ack,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    import noc_pkg::*;

    localparam int WORD_W = 2 * NOC_WID;

    logic [WORD_W-1:0] req_word [N_REQ];
    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_empty;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [NOC_WID-1:0] pair_ok;

            assign req_word[gi] = req_d[gi*WORD_W +: WORD_W];

            for (genvar gj = 0; gj < NOC_WID; gj++) begin : g_pair
                assign pair_ok[gj] = pair_valid(req_word[gi][gj*PAIR_W +: PAIR_W]);
            end

            // Partially populated words are neither valid nor empty.
            assign req_valid[gi] = &pair_ok;
            assign req_empty[gi] = ~|req_word[gi];
        end
    endgenerate

    logic [ID_W-1:0] arb_winner;
    logic            arb_any;

    state_e            state_q,    state_d;
    logic [WORD_W-1:0] out_d_q,    out_d_d;
    logic [N_REQ-1:0]  req_ack_q,  req_ack_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;

    rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arb (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (arb_winner),
        .any_valid (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            out_d_q    <= '0;
            req_ack_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_d_q    <= out_d_d;
            req_ack_q  <= req_ack_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_d_d    = out_d_q;
        req_ack_d  = req_ack_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;

        case (state_q)
            IDLE: begin
                out_d_d   = '0;
                req_ack_d = '0;
                if (arb_any) begin
                    grant_id_d = arb_winner;
                    out_d_d    = req_word[arb_winner];
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (out_ack) begin
                    out_d_d               = '0;
                    req_ack_d             = '0;
                    req_ack_d[grant_id_q] = 1'b1;
                    state_d               = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for both sides to return to zero before re-arbitrating.
                if (req_empty[grant_id_q] && !out_ack) begin
                    req_ack_d = '0;
                    rr_ptr_d  = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                out_d_d   = '0;
                req_ack_d = '0;
            end
        endcase
    end

    assign req_ack  = req_ack_q;
    assign out_d    = out_d_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_noc_tx_arb.sv
// Self-checking bench for noc_tx_arb (NOC_WID=4, N_REQ=4): directed scenarios with
// literal expectations plus randomized four-phase traffic against a transfer-level model.
module tb_noc_tx_arb;

    localparam int NW = 4;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    w [NR];
    logic [31:0]   req_d;
    logic [3:0]    req_ack;
    logic [7:0]    out_d;
    logic          out_ack = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Transfer-level reference: who owns the port, whether downstream has acknowledged.
    int         m_owner = -1;
    int         m_gid   = 0;
    int         m_ptr   = 0;
    bit         m_acked = 1'b0;
    logic [7:0] m_out   = '0;

    assign req_d = {w[3], w[2], w[1], w[0]};

    always #5 clk = ~clk;

    noc_tx_arb #(
        .NOC_WID (NW),
        .N_REQ   (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_d    (req_d),
        .req_ack  (req_ack),
        .out_d    (out_d),
        .out_ack  (out_ack),
        .grant_id (grant_id),
        .busy     (busy)
    );

    function automatic bit word_valid(input logic [7:0] x);
        for (int i = 0; i < NW; i++) begin
            if (x[2*i +: 2] == 2'b00) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gid   = 0;
        m_ptr   = 0;
        m_acked = 1'b0;
        m_out   = '0;
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (m_ptr + i) % NR;
                if (word_valid(w[k])) begin
                    m_owner = k;
                    m_gid   = k;
                    m_out   = w[k];
                    m_acked = 1'b0;
                    $display("TXN grant req %0d word %b at %0t", k, w[k], $time);
                    break;
                end
            end
        end else if (!m_acked) begin
            if (out_ack) begin
                m_acked = 1'b1;
                m_out   = '0;
            end
        end else if (w[m_owner] == 8'h00 && !out_ack) begin
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
            m_acked = 1'b0;
        end
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then compare.
    task automatic cycle();
        logic [3:0] exp_ack;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_step();
        exp_ack = (m_acked && m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk("model_out_d",    32'(out_d),    32'(m_out));
        chk("model_grant_id", 32'(grant_id), 32'(m_gid));
        chk("model_req_ack",  32'(req_ack),  32'(exp_ack));
        chk("model_busy",     32'(busy),     32'(m_owner >= 0));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        out_ack = 1'b0;
        for (int k = 0; k < NR; k++) w[k] = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic finish_xfer(input int k);
        out_ack = 1'b1;
        cycle();
        out_ack = 1'b0;
        w[k]    = '0;
        cycle();
    endtask

    int         phase [NR];
    int         wait_cnt [NR];
    logic [7:0] rnd_word;

    initial begin
        for (int k = 0; k < NR; k++) w[k] = '0;

        // Reset state
        do_reset();
        chk("reset_busy",    32'(busy),    32'h0);
        chk("reset_out_d",   32'(out_d),   32'h0);
        chk("reset_req_ack", 32'(req_ack), 32'h0);

        // Single transfer
        w[2] = 8'b10100101;
        cycle();
        chk("single_out_d", 32'(out_d), 32'hA5);
        chk("single_grant", 32'(grant_id), 32'd2);
        out_ack = 1'b1;
        cycle();
        chk("single_req_ack", 32'(req_ack), 32'b0100);
        chk("single_out_clr", 32'(out_d), 32'h0);
        w[2]    = '0;
        out_ack = 1'b0;
        cycle();
        chk("single_ack_clr", 32'(req_ack), 32'h0);
        chk("single_idle",    32'(busy),    32'h0);

        // Contention and pointer wrap
        do_reset();
        w[0] = 8'h55;
        w[1] = 8'h66;
        w[3] = 8'h9A;
        cycle();
        chk("rr_first_0", 32'(grant_id), 32'd0);
        finish_xfer(0);
        w[0] = 8'h55;
        cycle();
        chk("rr_second_1", 32'(grant_id), 32'd1);
        finish_xfer(1);
        cycle();
        chk("rr_third_3", 32'(grant_id), 32'd3);
        finish_xfer(3);
        cycle();
        chk("rr_wrap_0", 32'(grant_id), 32'd0);
        finish_xfer(0);

        // Partial word is held off until complete
        w[1] = 8'b00100101;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("partial_busy",  32'(busy),  32'h0);
            chk("partial_out_d", 32'(out_d), 32'h0);
        end
        w[1] = 8'b10100101;
        cycle();
        chk("partial_grant", 32'(grant_id), 32'd1);
        chk("partial_out_d_done", 32'(out_d), 32'hA5);
        finish_xfer(1);

        // Latched word ignores later input changes
        w[0] = 8'b01010101;
        cycle();
        chk("stable_first", 32'(out_d), 32'h55);
        w[0] = 8'b10101010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stable_hold", 32'(out_d), 32'h55);
        end
        finish_xfer(0);

        // Asynchronous reset in RELEASE restarts arbitration at requester 0
        w[1] = 8'hA5;
        cycle();
        out_ack = 1'b1;
        cycle();
        chk("arst_pre_ack", 32'(req_ack), 32'b0010);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_req_ack", 32'(req_ack), 32'h0);
        chk("arst_out_d",   32'(out_d),   32'h0);
        chk("arst_busy",    32'(busy),    32'h0);
        w[1]    = '0;
        out_ack = 1'b0;
        w[2]    = 8'hA5;
        w[0]    = 8'h55;
        cycle();
        rst = 1'b0;
        cycle();
        chk("arst_first_0", 32'(grant_id), 32'd0);
        finish_xfer(0);
        cycle();
        chk("arst_then_2", 32'(grant_id), 32'd2);
        finish_xfer(2);

        // Held acknowledge keeps RELEASE; 11 pairs forwarded unchanged
        w[3] = 8'b11011011;
        cycle();
        chk("both_rails_out_d", 32'(out_d), 32'hDB);
        out_ack = 1'b1;
        cycle();
        w[3] = '0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("held_req_ack", 32'(req_ack), 32'b1000);
            chk("held_busy",    32'(busy),    32'h1);
        end
        out_ack = 1'b0;
        cycle();
        chk("held_release", 32'(req_ack), 32'h0);

        // Randomized four-phase traffic
        for (int k = 0; k < NR; k++) begin
            phase[k]    = 0;
            wait_cnt[k] = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            cycle();
            for (int k = 0; k < NR; k++) begin
                case (phase[k])
                    0: if ($urandom_range(0, 3) == 0) begin
                        for (int p = 0; p < NW; p++) rnd_word[2*p +: 2] = 2'($urandom_range(1, 3));
                        if ($urandom_range(0, 3) == 0) begin
                            rnd_word[7:6] = 2'b00;
                            phase[k]      = 1;
                        end else begin
                            phase[k] = 2;
                        end
                        w[k]        = rnd_word;
                        wait_cnt[k] = 0;
                    end
                    1: begin
                        w[k][7:6] = 2'($urandom_range(1, 3));
                        phase[k]  = 2;
                    end
                    2: begin
                        wait_cnt[k]++;
                        if (req_ack[k]) begin
                            checks++;
                            if ($urandom_range(0, 1) == 0) begin
                                w[k]     = '0;
                                phase[k] = 3;
                            end
                        end else if (wait_cnt[k] > 500) begin
                            errors++;
                            $display("FAIL lost_request req %0d waited %0d cycles required <= 500", k, wait_cnt[k]);
                            wait_cnt[k] = 0;
                        end
                    end
                    default: begin
                        w[k] = '0;
                        if (!req_ack[k]) phase[k] = 0;
                    end
                endcase
            end
            if (out_d != 8'h00)                 out_ack = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 2) != 0) out_ack = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
